router_pkt_gen: RTL and testbench

ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_lfsr.sv | 29 ++
 rtl/router_pkt_gen.sv | 122 ++++++++++++
 tb/tb_router_pkt_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and defaults for the router packet generator.
// Holds the FSM state encoding, default parameter values and the LFSR feedback taps.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_t;

  localparam int          DEF_DATA_W    = 8;
  localparam int          DEF_ADDR_W    = 2;
  localparam int          DEF_LEN_W     = 6;
  localparam int          DEF_NUM_CH    = 3;
  localparam logic [7:0]  DEF_LFSR_SEED = 8'hA5;

  // x^8+x^6+x^5+x^4+1 feedback taps for the left-shifting Fibonacci LFSR
  localparam logic [31:0] LFSR_TAPS     = 32'h0000_00B8;

endpackage

// File: rtl/router_lfsr.sv
// Fibonacci LFSR payload source: shifts left, feedback is the XOR of the tapped bits.
// Advances only when step is high; reset reloads SEED.
module router_lfsr
  import router_pkg::*;
#(
  parameter int               WIDTH = DEF_DATA_W,
  parameter logic [WIDTH-1:0] SEED  = DEF_LFSR_SEED
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;
  logic             w_fb;

  assign w_fb  = ^(r_value & LFSR_TAPS[WIDTH-1:0]);
  assign value = r_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_value <= SEED;
    end else if (step) begin
      r_value <= {r_value[WIDTH-2:0], w_fb};
    end
  end

endmodule

// File: rtl/router_pkt_gen.sv
// Router stimulus generator: emits header, len payload bytes, a parity byte and one gap cycle.
// Outputs decode from registered state, so busy=1 freezes the presented byte and all counters.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                LEN_W     = DEF_LEN_W,
  parameter int                NUM_CH    = DEF_NUM_CH,
  parameter logic [DATA_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_mode,
  input  logic              cfg_err_inj,
  input  logic              busy,
  output logic [DATA_W-1:0] data_in,
  output logic              pkt_valid,
  output logic              gen_busy,
  output logic              done,
  output logic              cfg_err,
  output logic [15:0]       pkt_count
);

  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_mode, r_err_inj, r_cfg_err;
  logic [DATA_W-1:0] r_parity;
  logic [15:0]       r_pkt_count;
  logic [DATA_W-1:0] w_lfsr, w_payload, w_header;
  logic              w_cfg_ok, w_latch, w_pay_acc, w_last;

  assign w_cfg_ok  = (cfg_len != '0) && (int'(cfg_addr) < NUM_CH);
  assign w_latch   = (r_state == ST_IDLE) && start && w_cfg_ok;
  assign w_header  = {r_len, r_addr};
  assign w_payload = r_mode ? DATA_W'(r_cnt) : w_lfsr;
  assign w_pay_acc = (r_state == ST_PAYLOAD) && !busy;
  assign w_last    = (r_cnt == r_len - LEN_W'(1));

  assign gen_busy  = (r_state != ST_IDLE);
  assign cfg_err   = r_cfg_err;
  assign pkt_count = r_pkt_count;

  // Counter-mode packets leave the LFSR untouched so LFSR streams stay continuous
  router_lfsr #(
    .WIDTH (DATA_W),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (w_pay_acc && !r_mode),
    .value (w_lfsr)
  );

  always_comb begin
    w_next    = r_state;
    data_in   = '0;
    pkt_valid = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_latch) w_next = ST_HEADER;
      end
      ST_HEADER: begin
        data_in   = w_header;
        pkt_valid = 1'b1;
        if (!busy) w_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        data_in   = w_payload;
        pkt_valid = 1'b1;
        if (!busy && w_last) w_next = ST_PARITY;
      end
      ST_PARITY: begin
        data_in = r_parity ^ DATA_W'(r_err_inj);
        if (!busy) w_next = ST_GAP;
      end
      ST_GAP: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_addr      <= '0;
      r_mode      <= 1'b0;
      r_err_inj   <= 1'b0;
      r_cnt       <= '0;
      r_parity    <= '0;
      r_cfg_err   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_state   <= w_next;
      r_cfg_err <= (r_state == ST_IDLE) && start && !w_cfg_ok;
      if (w_latch) begin
        r_len     <= cfg_len;
        r_addr    <= cfg_addr;
        r_mode    <= cfg_mode;
        r_err_inj <= cfg_err_inj;
        r_cnt     <= '0;
        r_parity  <= {cfg_len, cfg_addr};
      end
      if (w_pay_acc) begin
        r_cnt    <= r_cnt + LEN_W'(1);
        r_parity <= r_parity ^ w_payload;
      end
      if ((r_state == ST_PARITY) && !busy) begin
        r_pkt_count <= r_pkt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Bench for router_pkt_gen: packet-level reference model compared every cycle,
// plus directed packets with hand-computed literal expectations.
module tb_router_pkt_gen;

  localparam int NCH = 3;

  logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [5:0]  cfg_len = '0;
  logic        cfg_mode = 1'b0, cfg_err_inj = 1'b0, busy = 1'b0;
  logic [7:0]  data_in;
  logic        pkt_valid, gen_busy, done, cfg_err;
  logic [15:0] pkt_count;

  int checks = 0;
  int failures = 0;

  router_pkt_gen dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cfg_addr    (cfg_addr),
    .cfg_len     (cfg_len),
    .cfg_mode    (cfg_mode),
    .cfg_err_inj (cfg_err_inj),
    .busy        (busy),
    .data_in     (data_in),
    .pkt_valid   (pkt_valid),
    .gen_busy    (gen_busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .pkt_count   (pkt_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet is the list of bytes it will present, walked one entry per accepted byte.
  logic [7:0]  m_bytes[$];
  int          m_idx = 0;
  bit          m_active = 0, m_gap = 0, m_cfg_err = 0;
  logic [15:0] m_count = '0;
  logic [7:0]  m_lfsr = 8'hA5;
  logic [7:0]  m_par, m_b;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_bytes.delete();
      m_idx = 0; m_active = 0; m_gap = 0; m_cfg_err = 0;
      m_count = '0; m_lfsr = 8'hA5;
    end else begin
      m_cfg_err = 0;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_active) begin
        if (!busy) begin
          if (m_idx == m_bytes.size() - 1) begin
            m_active = 0; m_gap = 1; m_count = m_count + 16'd1;
          end else begin
            m_idx++;
          end
        end
      end else if (start) begin
        if (cfg_len != 0 && int'(cfg_addr) < NCH) begin
          m_bytes.delete();
          m_par = {cfg_len, cfg_addr};
          m_bytes.push_back(m_par);
          for (int k = 0; k < int'(cfg_len); k++) begin
            if (cfg_mode) m_b = 8'(k);
            else begin
              m_b = m_lfsr;
              m_lfsr = lfsr_next(m_lfsr);
            end
            m_bytes.push_back(m_b);
            m_par ^= m_b;
          end
          m_bytes.push_back(m_par ^ {7'd0, cfg_err_inj});
          m_idx = 0; m_active = 1;
        end else begin
          m_cfg_err = 1;
        end
      end
    end
  end

  logic [7:0] e_data;
  bit         e_vld, e_gb, e_done;

  always @(negedge clock) begin
    if (!reset) begin
      if (m_gap) begin
        e_data = 8'h00; e_vld = 0; e_gb = 1; e_done = 1;
      end else if (m_active) begin
        e_data = m_bytes[m_idx]; e_vld = (m_idx < m_bytes.size() - 1); e_gb = 1; e_done = 0;
      end else begin
        e_data = 8'h00; e_vld = 0; e_gb = 0; e_done = 0;
      end
      chk("data_in",   data_in,   e_data);
      chk("pkt_valid", pkt_valid, e_vld);
      chk("gen_busy",  gen_busy,  e_gb);
      chk("done",      done,      e_done);
      chk("cfg_err",   cfg_err,   m_cfg_err);
      chk("pkt_count", pkt_count, m_count);
    end
  end

  task automatic setreq(input logic [1:0] a, input logic [5:0] l, input logic md, input logic inj);
    cfg_addr = a; cfg_len = l; cfg_mode = md; cfg_err_inj = inj; start = 1'b1;
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l, input logic md, input logic inj);
    @(posedge clock); #1;
    setreq(a, l, md, inj);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  int         done_at, nb5, last_done;
  bit         seen_vld, prev_vld;
  logic [7:0] par_seen;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data",  data_in,   8'h00);
    chk("rst_vld",   pkt_valid, 1'b0);
    chk("rst_busy",  gen_busy,  1'b0);
    chk("rst_count", pkt_count, 16'd0);

    // First start on the very first edge after reset release
    reset = 1'b0;
    setreq(2'd0, 6'd14, 1'b1, 1'b0);
    @(posedge clock); #1 start = 1'b0;
    done_at = 0; par_seen = '0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      if (c == 1) chk("hdr_len14", data_in, 8'h38);
      if (gen_busy && !pkt_valid && !done) par_seen = data_in;
      if (done && done_at == 0) done_at = c;
    end
    chk("par_len14",  par_seen,  8'h39);
    chk("done_len14", done_at,   17);
    chk("cnt_len14",  pkt_count, 16'd1);

    // Back-pressure on payload byte 5 for three edges
    send(2'd0, 6'd14, 1'b1, 1'b0);
    done_at = 0; nb5 = 0;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clock);
      if (c == 7) busy = 1'b1;
      if (c == 10) busy = 1'b0;
      if (pkt_valid && data_in == 8'h05) nb5++;
      if (gen_busy && !pkt_valid && !done) par_seen = data_in;
      if (done && done_at == 0) done_at = c;
    end
    chk("hold_byte5", nb5,       4);
    chk("par_busy",   par_seen,  8'h39);
    chk("done_busy",  done_at,   20);
    chk("cnt_busy",   pkt_count, 16'd2);

    // Parity corruption on a one-byte packet
    send(2'd1, 6'd1, 1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) chk("hdr_inj", data_in, 8'h05);
      if (c == 2) chk("pay_inj", data_in, 8'h00);
      if (c == 3) chk("par_inj", data_in, 8'h04);
      if (c == 4) chk("done_inj", done, 1'b1);
    end

    // Rejected requests
    send(2'd3, 6'd5, 1'b1, 1'b0);
    seen_vld = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) chk("cfgerr_addr", cfg_err, 1'b1);
      if (c == 2) chk("cfgerr_pulse", cfg_err, 1'b0);
      if (pkt_valid) seen_vld = 1;
    end
    send(2'd0, 6'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c == 1) chk("cfgerr_len0", cfg_err, 1'b1);
      if (pkt_valid) seen_vld = 1;
    end
    chk("rej_no_vld", seen_vld, 1'b0);
    chk("rej_count",  pkt_count, 16'd3);

    // Reset in the middle of a payload
    send(2'd2, 6'd20, 1'b1, 1'b0);
    for (int c = 1; c <= 9; c++) @(negedge clock);
    chk("pre_rst_byte7", data_in, 8'h07);
    #2 reset = 1'b1;
    #1;
    chk("arst_data",  data_in,   8'h00);
    chk("arst_vld",   pkt_valid, 1'b0);
    chk("arst_busy",  gen_busy,  1'b0);
    chk("arst_done",  done,      1'b0);
    chk("arst_count", pkt_count, 16'd0);
    @(posedge clock); #1 reset = 1'b0;
    send(2'd2, 6'd3, 1'b1, 1'b0);
    done_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) chk("hdr_after_rst", data_in, 8'h0E);
      if (done && done_at == 0) done_at = c;
    end
    chk("done_after_rst", done_at,   6);
    chk("cnt_after_rst",  pkt_count, 16'd1);

    // Start held high: max-length LFSR packets back to back
    @(posedge clock); #1;
    setreq(2'd1, 6'd63, 1'b0, 1'b0);
    last_done = 0; prev_vld = 0;
    for (int c = 1; c <= 220; c++) begin
      @(negedge clock);
      if (pkt_valid && !prev_vld && last_done > 0) chk("b2b_spacing", c - last_done, 2);
      if (done) last_done = c;
      prev_vld = pkt_valid;
    end
    @(posedge clock); #1 start = 1'b0;

    // Randomized traffic with back-pressure and occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock); #1;
      busy        = ($urandom_range(0, 3) == 0);
      start       = ($urandom_range(0, 2) == 0);
      cfg_addr    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       cfg_len = 6'd0;
        1:       cfg_len = 6'd63;
        default: cfg_len = 6'($urandom_range(1, 20));
      endcase
      cfg_mode    = 1'($urandom_range(0, 1));
      cfg_err_inj = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    start = 1'b0; busy = 1'b0;
    repeat (80) @(posedge clock);
    @(negedge clock);
    chk("final_idle", gen_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
